// File: rtl/frame_read_engine.sv
`default_nettype none
// ============================================================================
//  Module      : frame_read_engine
//  Description : Scan-out reader for a 320x240 SDRAM framebuffer. Issues
//                sequential single-word read requests, buffers returned pixel
//                words in a small FIFO for the display pipeline, wraps at the
//                end of the frame and flags consumer underflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_read_engine #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              Frame_Start,
    output logic              Read,
    output logic [ADDR_W-1:0] R_Address,
    input  logic              Busy,
    input  logic              Read_Valid,
    input  logic [DATA_W-1:0] Read_Data,
    input  logic              Pixel_Req,
    output logic [DATA_W-1:0] Pixel_Data,
    output logic              Pixel_Valid,
    output logic [9:0]        Row,
    output logic [9:0]        Col,
    output logic              Frame_Done,
    output logic              Underflow
);

    localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [9:0]       LAST_COL = 10'(H_RES - 1);
    localparam logic [9:0]       LAST_ROW = 10'(V_RES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                read_q, read_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [9:0]          row_q, row_d;
    logic [9:0]          col_q, col_d;
    logic                frame_done_q, frame_done_d;
    logic                underflow_q, underflow_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

    logic fifo_empty;
    logic push;
    logic pop;
    logic at_max;
    logic room_after;

    assign fifo_empty = (count_q == '0);
    // Only the word of a live outstanding read is kept; Frame_Start discards it.
    assign push       = (state_q == S_WAIT) && Read_Valid && !Frame_Start;
    assign pop        = Pixel_Req && !fifo_empty;
    assign at_max     = (row_q == LAST_ROW) && (col_q == LAST_COL);
    assign room_after = (count_d < DEPTH_C);

    // Next-state computation: FIFO bookkeeping, address scan, request FSM.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        row_d        = row_q;
        col_d        = col_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        underflow_d  = underflow_q | (Pixel_Req & fifo_empty);
        frame_done_d = push & at_max;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Scan position advances once per stored word; the flat address is
        // tracked alongside Row/Col so no multiplier is needed.
        if (push) begin
            if (at_max) begin
                addr_d = '0;
                row_d  = '0;
                col_d  = '0;
            end else if (col_q == LAST_COL) begin
                addr_d = addr_q + ADDR_W'(1);
                row_d  = row_q + 10'd1;
                col_d  = '0;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
                col_d  = col_q + 10'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (Enable && (count_q < DEPTH_C)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!Busy) begin
                    state_d = S_WAIT;
                end else if (!Enable) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT, S_DRAIN: begin
                if (Read_Valid) begin
                    state_d = (Enable && room_after) ? S_REQ : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Restart of the scan overrides everything. A read already accepted by
        // the controller must still be waited out, so those paths go to DRAIN.
        if (Frame_Start) begin
            addr_d       = '0;
            row_d        = '0;
            col_d        = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            underflow_d  = 1'b0;
            frame_done_d = 1'b0;
            case (state_q)
                S_REQ:           state_d = Busy ? S_IDLE : S_DRAIN;
                S_WAIT, S_DRAIN: state_d = Read_Valid ? S_IDLE : S_DRAIN;
                default:         state_d = S_IDLE;
            endcase
        end

        read_d = (state_d == S_REQ);
    end

    // Control and status registers with asynchronous clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            read_q       <= 1'b0;
            addr_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            read_q       <= read_d;
            addr_q       <= addr_d;
            row_q        <= row_d;
            col_q        <= col_d;
            frame_done_q <= frame_done_d;
            underflow_q  <= underflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Pixel storage; contents are don't-care until pointed at by a valid count.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= Read_Data;
        end
    end

    // The room check before each request guarantees a free slot for every return.
    a_no_overflow: assert property (@(posedge Clk) disable iff (Reset) push |-> (count_q < DEPTH_C));

    assign Read        = read_q;
    assign R_Address   = addr_q;
    assign Row         = row_q;
    assign Col         = col_q;
    assign Frame_Done  = frame_done_q;
    assign Underflow   = underflow_q;
    assign Pixel_Valid = !fifo_empty;
    assign Pixel_Data  = fifo_empty ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_frame_read_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_frame_read_engine
//  Description : Scoreboard bench for frame_read_engine. A small SDRAM model
//                answers accepted reads; expected pixels are queued when the
//                model returns a live word and compared as the consumer pops.
//                A reduced frame size lets the scan wrap many times.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_read_engine;

    localparam int H_RES  = 24;
    localparam int V_RES  = 5;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int TOTAL  = H_RES * V_RES;

    logic              Clk         = 1'b0;
    logic              Reset       = 1'b1;
    logic              Enable      = 1'b0;
    logic              Frame_Start = 1'b0;
    logic              Busy        = 1'b0;
    logic              Read_Valid  = 1'b0;
    logic [DATA_W-1:0] Read_Data   = '0;
    logic              Pixel_Req   = 1'b0;
    logic              Read;
    logic [ADDR_W-1:0] R_Address;
    logic [DATA_W-1:0] Pixel_Data;
    logic              Pixel_Valid;
    logic [9:0]        Row;
    logic [9:0]        Col;
    logic              Frame_Done;
    logic              Underflow;

    frame_read_engine #(
        .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Frame_Start(Frame_Start),
        .Read(Read), .R_Address(R_Address), .Busy(Busy), .Read_Valid(Read_Valid),
        .Read_Data(Read_Data), .Pixel_Req(Pixel_Req), .Pixel_Data(Pixel_Data),
        .Pixel_Valid(Pixel_Valid), .Row(Row), .Col(Col), .Frame_Done(Frame_Done),
        .Underflow(Underflow)
    );

    initial forever #5 Clk = ~Clk;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] pop_log[$];
    int  acc_log[$];
    int  exp_addr   = 0;
    bit  fd_next    = 1'b0;
    bit  exp_uf     = 1'b0;
    bit  pend       = 1'b0;
    bit  pend_live  = 1'b0;
    int  pend_addr  = 0;
    int  pend_delay = 0;
    int  accepts    = 0;
    int  frame_dones = 0;
    int  busy_pct   = 0;
    int  lat_min    = 1;
    int  lat_max    = 1;
    int  hold_addr  = 7;
    int  hold_left  = 5;
    int  hold_seen  = 0;
    int  hold_acc   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DATA_W-1:0] data_of(input int a);
        return DATA_W'(32'hA000 + a);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_read", Read, 0);
        check("rst_addr", R_Address, 0);
        check("rst_row", Row, 0);
        check("rst_col", Col, 0);
        check("rst_pixel_valid", Pixel_Valid, 0);
        check("rst_pixel_data", Pixel_Data, 0);
        check("rst_frame_done", Frame_Done, 0);
        check("rst_underflow", Underflow, 0);
    endtask

    // SDRAM model and address/frame bookkeeping; acts mid-cycle after the monitor.
    initial begin
        forever begin
            @(negedge Clk);
            #2;
            if (Reset) begin
                exp_q.delete();
                pend_live = 1'b0;
                exp_addr  = 0;
                fd_next   = 1'b0;
                if (Read_Valid) pend = 1'b0;
            end else begin
                check("addr", R_Address, exp_addr);
                check("row", Row, exp_addr / H_RES);
                check("col", Col, exp_addr % H_RES);
                check("frame_done", Frame_Done, fd_next);
                if (Frame_Done) frame_dones++;
                fd_next = 1'b0;
                if (Read && R_Address == hold_addr) begin
                    if (Busy) hold_seen++;
                    else hold_acc++;
                end
                if (Read_Valid) begin
                    if (pend_live && !Frame_Start) begin
                        exp_q.push_back(data_of(pend_addr));
                        if (pend_addr == TOTAL - 1) fd_next = 1'b1;
                        exp_addr = (pend_addr + 1) % TOTAL;
                    end
                    pend = 1'b0;
                end
                if (Read && !Busy) begin
                    check("one_outstanding", pend, 0);
                    check("req_addr", R_Address, exp_addr);
                    pend       = 1'b1;
                    pend_live  = 1'b1;
                    pend_addr  = int'(R_Address);
                    pend_delay = int'($urandom_range(lat_max, lat_min));
                    acc_log.push_back(int'(R_Address));
                    accepts++;
                end
                if (Frame_Start) begin
                    exp_q.delete();
                    exp_addr  = 0;
                    pend_live = 1'b0;
                end
            end
            @(posedge Clk);
            #1;
            Read_Valid = 1'b0;
            if (pend) begin
                if (pend_delay == 0) begin
                    Read_Valid = 1'b1;
                    Read_Data  = data_of(pend_addr);
                end else begin
                    pend_delay--;
                end
            end
            if (Read && hold_left > 0 && R_Address == hold_addr) begin
                Busy = 1'b1;
                hold_left--;
            end else begin
                Busy = ($urandom_range(99, 0) < busy_pct);
            end
        end
    end

    // Monitor: pops compared against the expected pixel queue; underflow model.
    initial begin
        forever begin
            @(negedge Clk);
            if (Reset) begin
                exp_uf = 1'b0;
            end else begin
                check("underflow", Underflow, exp_uf);
                check("pixel_valid", Pixel_Valid, exp_q.size() != 0);
                if (Pixel_Req && Pixel_Valid && exp_q.size() != 0) begin
                    check("pixel_data", Pixel_Data, exp_q[0]);
                    pop_log.push_back(Pixel_Data);
                    void'(exp_q.pop_front());
                end
                if (Frame_Start) exp_uf = 1'b0;
                else if (Pixel_Req && !Pixel_Valid) exp_uf = 1'b1;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;
        bit found;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_values();
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Sequential fetch with fixed latency, then drain in order (hold at 7 on the way)
        Enable = 1'b1;
        step(20);
        for (int i = 0; i < 40; i++) begin
            Pixel_Req = Pixel_Valid;
            step(1);
        end
        Pixel_Req = 1'b0;
        check("accept_log_len", acc_log.size() >= 3, 1);
        if (acc_log.size() >= 3) begin
            check("accept_0", acc_log[0], 0);
            check("accept_1", acc_log[1], 1);
            check("accept_2", acc_log[2], 2);
        end
        check("pop_log_len", pop_log.size() >= 3, 1);
        if (pop_log.size() >= 3) begin
            check("pop_0", pop_log[0], 16'hA000);
            check("pop_1", pop_log[1], 16'hA001);
            check("pop_2", pop_log[2], 16'hA002);
        end
        check("hold_busy_cycles", hold_seen, 5);
        check("hold_accepts", hold_acc, 1);
        hold_addr = -1;

        // Fill to capacity, single-pop credit, then underflow
        step(70);
        check("full_read_low", Read, 0);
        check("full_words", exp_q.size(), DEPTH);
        check("full_valid", Pixel_Valid, 1);
        a0 = accepts;
        step(5);
        check("full_no_accept", accepts - a0, 0);
        Pixel_Req = 1'b1;
        step(1);
        Pixel_Req = 1'b0;
        step(15);
        check("one_pop_one_req", accepts - a0, 1);
        check("refill_words", exp_q.size(), DEPTH);
        Enable    = 1'b0;
        Pixel_Req = 1'b1;
        step(22);
        Pixel_Req = 1'b0;
        step(1);
        check("underflow_set", Underflow, 1);
        step(5);
        check("underflow_sticky", Underflow, 1);

        // Frame_Start while waiting on the read of address 50
        lat_min = 2;
        lat_max = 2;
        Enable  = 1'b1;
        found   = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            Pixel_Req = Pixel_Valid && ($urandom_range(1, 0) == 1);
            if (pend && pend_live && pend_addr == 50 && !Read) found = 1'b1;
            else step(1);
        end
        check("reach_addr_50", found, 1);
        Frame_Start = 1'b1;
        Pixel_Req   = 1'b0;
        step(1);
        Frame_Start = 1'b0;
        check("fs_underflow_clear", Underflow, 0);
        check("fs_fifo_empty", Pixel_Valid, 0);
        check("fs_addr_zero", R_Address, 0);
        a0    = accepts;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (accepts != a0) found = 1'b1;
            else step(1);
        end
        check("fs_reaccept", found, 1);
        if (found) check("fs_first_addr", acc_log[$], 0);

        // Randomized traffic across several frame wraps
        busy_pct = 30;
        lat_min  = 0;
        lat_max  = 3;
        for (int i = 0; i < 4000; i++) begin
            Enable      = ($urandom_range(9, 0) != 0);
            Pixel_Req   = ($urandom_range(1, 0) == 1);
            Frame_Start = ($urandom_range(1499, 0) == 0);
            step(1);
        end
        Frame_Start = 1'b0;
        Pixel_Req   = 1'b0;
        check("frame_done_seen", frame_dones > 0, 1);

        // Asynchronous reset while a read is outstanding
        busy_pct = 0;
        lat_min  = 4;
        lat_max  = 4;
        Enable   = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            Pixel_Req = Pixel_Valid && ($urandom_range(3, 0) == 0);
            if (pend && pend_live && !Read) found = 1'b1;
            else step(1);
        end
        check("reach_wait", found, 1);
        #2;
        Reset = 1'b1;
        #1;
        check_reset_values();
        Enable    = 1'b0;
        Pixel_Req = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        step(10);
        check("post_reset_valid", Pixel_Valid, 0);
        check("post_reset_read", Read, 0);
        check("post_reset_addr", R_Address, 0);
        check("stale_return_done", pend, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
